// File: rtl/sel_pkg.sv
// Shared types and constants for the register select-and-encode unit.
package sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_RB = 2'd1,
        S_RC = 2'd2,
        S_RA = 2'd3
    } seq_state_e;

    // Field positions for the default 32-bit instruction with a 5-bit opcode.
    localparam int RA_HI_DEF = 26;
    localparam int RB_HI_DEF = 22;
    localparam int RC_HI_DEF = 18;
    localparam int IMM_HI_DEF = 18;

endpackage

// File: rtl/sel_encode_seq_if.sv
// Control-unit <-> select/encode bundle; master is the control side, slave the unit.
interface sel_encode_seq_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int DATA_W  = 32
);
    localparam int NUM_REGS = 2**REG_AW;

    logic                       ir_ld;
    logic [INSTR_W-1:0]         instr_in;
    logic                       Gra;
    logic                       Grb;
    logic                       Grc;
    logic                       Rin;
    logic                       Rout;
    logic                       BAout;
    logic                       seq_start;
    logic                       seq_imm;
    logic [NUM_REGS-1:0]        reg_in;
    logic [NUM_REGS-1:0]        reg_out;
    logic                       imm_out;
    logic                       zero_out;
    logic signed [DATA_W-1:0]   c_sext;
    logic                       seq_busy;
    logic                       seq_done;

    modport master (
        output ir_ld, instr_in, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_imm,
        input  reg_in, reg_out, imm_out, zero_out, c_sext, seq_busy, seq_done
    );

    modport slave (
        input  ir_ld, instr_in, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_imm,
        output reg_in, reg_out, imm_out, zero_out, c_sext, seq_busy, seq_done
    );

endinterface

// File: rtl/onehot_dec.sv
// Register-number to one-hot enable decoder; all zeros when disabled.
module onehot_dec #(
    parameter int REG_AW = 4
) (
    input  logic                   en_i,
    input  logic [REG_AW-1:0]      sel_i,
    output logic [2**REG_AW-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/sel_encode_seq.sv
// Instruction register, Ra/Rb/Rc one-hot select, immediate sign-extension and
// a three-step operand sequencer. Optional macro SEL_BA_ZERO_EN: BAout on R0 drives zero_out.
module sel_encode_seq
    import sel_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 5,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 19,
    parameter int DATA_W  = 32
) (
    input  logic           clk,
    input  logic           clr,
    sel_encode_seq_if.slave bus
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam int RA_HI    = INSTR_W - OPC_W - 1;
    localparam int RB_HI    = RA_HI - REG_AW;
    localparam int RC_HI    = RB_HI - REG_AW;

    seq_state_e                 state_q, state_d;
    logic [INSTR_W-1:0]         ir_q, ir_d;
    logic                       imm_sel_q, imm_sel_d;
    logic [NUM_REGS-1:0]        reg_in_q, reg_in_d;
    logic [NUM_REGS-1:0]        reg_out_q, reg_out_d;
    logic                       imm_out_q, imm_out_d;
    logic                       zero_q, zero_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic signed [DATA_W-1:0]   c_sext_q;

    logic [REG_AW-1:0]          ra_d, rb_d, rc_d, field;
    logic [REG_AW-1:0]          in_sel, out_sel;
    logic                       in_en, out_en;
    logic                       unused_opc;

    assign unused_opc = ^ir_q[INSTR_W-1 -: OPC_W];

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [INSTR_W-1:0] ir);
        logic signed [IMM_W-1:0] imm;
        imm = ir[IMM_W-1:0];
        return DATA_W'(imm);
    endfunction

    onehot_dec #(.REG_AW(REG_AW)) u_dec_in (
        .en_i     (in_en),
        .sel_i    (in_sel),
        .onehot_o (reg_in_d)
    );

    onehot_dec #(.REG_AW(REG_AW)) u_dec_out (
        .en_i     (out_en),
        .sel_i    (out_sel),
        .onehot_o (reg_out_d)
    );

    // Next state and next outputs; fields come from ir_d so a load in the
    // same cycle as seq_start is used by the sequence.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        imm_sel_d = imm_sel_q;
        in_en     = 1'b0;
        in_sel    = '0;
        out_en    = 1'b0;
        out_sel   = '0;
        imm_out_d = 1'b0;
        zero_d    = 1'b0;
        done_d    = 1'b0;
        field     = '0;

        if (state_q == IDLE && bus.ir_ld) begin
            ir_d = bus.instr_in;
        end
        ra_d = ir_d[RA_HI -: REG_AW];
        rb_d = ir_d[RB_HI -: REG_AW];
        rc_d = ir_d[RC_HI -: REG_AW];

        unique case (state_q)
            IDLE: begin
                if (bus.seq_start) begin
                    state_d   = S_RB;
                    imm_sel_d = bus.seq_imm;
                    out_en    = 1'b1;
                    out_sel   = rb_d;
                end else if (bus.Gra || bus.Grb || bus.Grc) begin
                    field   = bus.Gra ? ra_d : (bus.Grb ? rb_d : rc_d);
                    in_en   = bus.Rin;
                    in_sel  = field;
                    out_sel = field;
`ifdef SEL_BA_ZERO_EN
                    out_en  = bus.Rout || (bus.BAout && field != '0);
                    zero_d  = bus.BAout && field == '0;
`else
                    out_en  = bus.Rout || bus.BAout;
`endif
                end
            end
            S_RB: begin
                state_d = S_RC;
                if (imm_sel_q) begin
                    imm_out_d = 1'b1;
                end else begin
                    out_en  = 1'b1;
                    out_sel = rc_d;
                end
            end
            S_RC: begin
                state_d = S_RA;
                in_en   = 1'b1;
                in_sel  = ra_d;
            end
            S_RA: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Registered state and outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            imm_sel_q <= 1'b0;
            reg_in_q  <= '0;
            reg_out_q <= '0;
            imm_out_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            c_sext_q  <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_sel_q <= imm_sel_d;
            reg_in_q  <= reg_in_d;
            reg_out_q <= reg_out_d;
            imm_out_q <= imm_out_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            c_sext_q  <= sext_imm(ir_q);
        end
    end

    assign bus.reg_in   = reg_in_q;
    assign bus.reg_out  = reg_out_q;
    assign bus.imm_out  = imm_out_q;
    assign bus.zero_out = zero_q;
    assign bus.c_sext   = c_sext_q;
    assign bus.seq_busy = busy_q;
    assign bus.seq_done = done_q;

endmodule
